// File: rtl/VX_gpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : VX_gpu_pkg
// Purpose  : Shared definitions for the memory bus arbiter slice.
//            - log_n(): index width needed to name one of n requesters
//              (0 when there is a single requester).
//            - mem_arb_entry_t: layout of one buffered request in the
//              default configuration (30-bit address, 4-byte words,
//              8-bit requester tag, 4 requesters -> 10-bit memory tag).
//              The arbiter builds the same layout from its own parameters.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package VX_gpu_pkg;

    function automatic int log_n(input int n);
        return (n > 1) ? $clog2(n) : 0;
    endfunction

    localparam int c_DEF_NUM_REQS   = 4;
    localparam int c_DEF_ADDR_WIDTH = 30;
    localparam int c_DEF_DATA_SIZE  = 4;
    localparam int c_DEF_TAG_WIDTH  = 8;

    typedef struct packed {
        logic                                        rw;
        logic [c_DEF_ADDR_WIDTH-1:0]                 addr;
        logic [c_DEF_DATA_SIZE-1:0]                  byteen;
        logic [8*c_DEF_DATA_SIZE-1:0]                data;
        logic [c_DEF_TAG_WIDTH+2-1:0]                tag;
    } mem_arb_entry_t;

endpackage
`default_nettype wire

// File: rtl/vx_arb_elastic_buf.sv
`default_nettype none
// ============================================================================
// Module   : vx_arb_elastic_buf
// Purpose  : 2-entry valid/ready FIFO with a registered input-side ready.
//            o_ready is "not full" taken from a flop, so the upstream
//            arbiter never sees a combinational path from i_ready.
// Ports    : clk, reset (async, active-low)
//            i_valid/i_data/o_ready   - push side
//            o_valid/o_data/i_ready   - pop side (head of queue)
//            o_count_next             - occupancy after the coming edge
// Revision : 1.0 - initial release
// ============================================================================
module vx_arb_elastic_buf #(
    parameter int DATAW = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_valid,
    input  logic [DATAW-1:0] i_data,
    output logic             o_ready,
    output logic             o_valid,
    output logic [DATAW-1:0] o_data,
    input  logic             i_ready,
    output logic [1:0]       o_count_next
);

    logic [DATAW-1:0] r_mem [2];
    logic             r_rd_ptr;
    logic             r_wr_ptr;
    logic [1:0]       r_count;
    logic             r_ready;

    logic             w_push;
    logic             w_pop;
    logic [1:0]       w_count_next;

    assign w_push = i_valid && r_ready;
    assign w_pop  = (r_count != 2'd0) && i_ready;

    // Simultaneous push and pop leave the occupancy unchanged.
    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + 2'd1;
        end else if (w_pop && !w_push) begin
            w_count_next = r_count - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
            r_ready  <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= w_count_next;
            r_ready <= (w_count_next != 2'd2);
        end
    end

    // Payload storage needs no reset; validity is carried by r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_ready      = r_ready;
    assign o_valid      = (r_count != 2'd0);
    assign o_data       = r_mem[r_rd_ptr];
    assign o_count_next = w_count_next;

endmodule
`default_nettype wire

// File: rtl/vx_mem_bus_arb.sv
`default_nettype none
// ============================================================================
// Module   : vx_mem_bus_arb
// Purpose  : Round-robin arbiter merging NUM_REQS requesters onto one memory
//            request/response channel. The grant index is appended to the
//            tag LSBs so responses route back; per-requester pending-read
//            counters throttle reads and feed busy.
// Ports    : clk, reset (async, active-low)
//            req_*  [N]      - requester request channels, req_ready out
//            mem_req_*       - merged request from the elastic buffer head
//            mem_rsp_*       - memory response, mem_rsp_ready out
//            rsp_*  [N]      - routed responses (data broadcast)
//            busy            - registered: reads pending or buffer occupied
//            rsp_err         - sticky: response to requester with none pending
// Revision : 1.0 - initial release
// ============================================================================
module vx_mem_bus_arb
    import VX_gpu_pkg::*;
#(
    parameter int NUM_REQS    = 4,
    parameter int ADDR_WIDTH  = 30,
    parameter int DATA_SIZE   = 4,
    parameter int TAG_WIDTH   = 8,
    parameter int MAX_PENDING = 16
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic [NUM_REQS-1:0]                          req_valid,
    input  logic [NUM_REQS-1:0]                          req_rw,
    input  logic [NUM_REQS-1:0][ADDR_WIDTH-1:0]          req_addr,
    input  logic [NUM_REQS-1:0][DATA_SIZE-1:0]           req_byteen,
    input  logic [NUM_REQS-1:0][8*DATA_SIZE-1:0]         req_data,
    input  logic [NUM_REQS-1:0][TAG_WIDTH-1:0]           req_tag,
    output logic [NUM_REQS-1:0]                          req_ready,
    output logic                                         mem_req_valid,
    output logic                                         mem_req_rw,
    output logic [ADDR_WIDTH-1:0]                        mem_req_addr,
    output logic [DATA_SIZE-1:0]                         mem_req_byteen,
    output logic [8*DATA_SIZE-1:0]                       mem_req_data,
    output logic [TAG_WIDTH+log_n(NUM_REQS)-1:0]         mem_req_tag,
    input  logic                                         mem_req_ready,
    input  logic                                         mem_rsp_valid,
    input  logic [8*DATA_SIZE-1:0]                       mem_rsp_data,
    input  logic [TAG_WIDTH+log_n(NUM_REQS)-1:0]         mem_rsp_tag,
    output logic                                         mem_rsp_ready,
    output logic [NUM_REQS-1:0]                          rsp_valid,
    output logic [NUM_REQS-1:0][8*DATA_SIZE-1:0]         rsp_data,
    output logic [NUM_REQS-1:0][TAG_WIDTH-1:0]           rsp_tag,
    input  logic [NUM_REQS-1:0]                          rsp_ready,
    output logic                                         busy,
    output logic                                         rsp_err
);

    localparam int c_LOG_N  = log_n(NUM_REQS);
    localparam int c_IDX_W  = (c_LOG_N > 0) ? c_LOG_N : 1;
    localparam int c_MTAG_W = TAG_WIDTH + c_LOG_N;
    localparam int c_PEND_W = $clog2(MAX_PENDING + 1);
    localparam logic [c_PEND_W-1:0] c_PEND_MAX  = c_PEND_W'(MAX_PENDING);
    localparam logic [c_IDX_W:0]    c_NUM_REQS_W = (c_IDX_W+1)'(NUM_REQS);

    // Same field order as mem_arb_entry_t, sized by this instance.
    typedef struct packed {
        logic                   rw;
        logic [ADDR_WIDTH-1:0]  addr;
        logic [DATA_SIZE-1:0]   byteen;
        logic [8*DATA_SIZE-1:0] data;
        logic [c_MTAG_W-1:0]    tag;
    } entry_t;

    localparam int c_DATAW = $bits(entry_t);

    logic [c_IDX_W-1:0]               r_rr_ptr;
    logic [NUM_REQS-1:0][c_PEND_W-1:0] r_pend;
    logic                              r_busy;
    logic                              r_err;

    logic [NUM_REQS-1:0]               w_elig;
    logic [NUM_REQS-1:0]               w_rot;
    logic                              w_gnt_valid;
    logic [c_IDX_W-1:0]                w_gnt_idx;
    logic [c_IDX_W:0]                  w_scan_sum;
    logic [NUM_REQS-1:0]               w_gnt_onehot;
    logic [c_IDX_W:0]                  w_ptr_sum;
    logic [c_IDX_W-1:0]                w_ptr_next;
    logic                              w_buf_in_ready;
    logic                              w_buf_ready;
    logic                              w_req_fire;
    logic [c_MTAG_W-1:0]               w_in_tag;
    entry_t                            w_in;
    entry_t                            w_head;
    logic [c_DATAW-1:0]                w_head_bits;
    logic                              w_buf_valid;
    logic [1:0]                        w_count_next;

    logic [c_IDX_W-1:0]                w_rsp_idx;
    logic                              w_rsp_in_range;
    logic                              w_rsp_fire;
    logic                              w_rsp_ok;
    logic [NUM_REQS-1:0]               w_rsp_onehot;
    logic [NUM_REQS-1:0]               w_inc;
    logic [NUM_REQS-1:0]               w_dec;
    logic [NUM_REQS-1:0][c_PEND_W-1:0] w_pend_next;
    logic                              w_any_pend;

    // ------------------------------------------------------------------
    // Round-robin grant: rotate eligibility so bit 0 is the pointer, take
    // the lowest set bit, then map the offset back to a requester index.
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NUM_REQS; i++) begin
            w_elig[i] = req_valid[i] && (req_rw[i] || (r_pend[i] != c_PEND_MAX));
        end
        w_rot       = NUM_REQS'({w_elig, w_elig} >> r_rr_ptr);
        w_gnt_valid = 1'b0;
        w_gnt_idx   = '0;
        w_scan_sum  = '0;
        for (int k = 0; k < NUM_REQS; k++) begin
            if (!w_gnt_valid && w_rot[k]) begin
                w_gnt_valid = 1'b1;
                w_scan_sum  = {1'b0, r_rr_ptr} + (c_IDX_W+1)'(k);
                if (w_scan_sum >= c_NUM_REQS_W) begin
                    w_scan_sum = w_scan_sum - c_NUM_REQS_W;
                end
                w_gnt_idx = w_scan_sum[c_IDX_W-1:0];
            end
        end
    end

    assign w_ptr_sum    = {1'b0, w_gnt_idx} + (c_IDX_W+1)'(1);
    assign w_ptr_next   = (w_ptr_sum >= c_NUM_REQS_W) ? '0 : w_ptr_sum[c_IDX_W-1:0];
    assign w_gnt_onehot = NUM_REQS'(1) << w_gnt_idx;

    // The buffer's ready flop resets to "not full"; gating with reset keeps
    // req_ready low while reset is held without delaying the first accept.
    assign w_buf_ready = w_buf_in_ready && reset;
    assign w_req_fire  = w_gnt_valid && w_buf_ready;
    assign req_ready   = w_req_fire ? w_gnt_onehot : '0;

    generate
        if (c_LOG_N > 0) begin : g_tag_idx
            assign w_in_tag  = {req_tag[w_gnt_idx], w_gnt_idx};
            assign w_rsp_idx = mem_rsp_tag[c_LOG_N-1:0];
        end else begin : g_tag_pass
            assign w_in_tag  = req_tag[w_gnt_idx];
            assign w_rsp_idx = '0;
        end
    endgenerate

    always_comb begin
        w_in.rw     = req_rw[w_gnt_idx];
        w_in.addr   = req_addr[w_gnt_idx];
        w_in.byteen = req_byteen[w_gnt_idx];
        w_in.data   = req_data[w_gnt_idx];
        w_in.tag    = w_in_tag;
    end

    vx_arb_elastic_buf #(
        .DATAW (c_DATAW)
    ) u_buf (
        .clk          (clk),
        .reset        (reset),
        .i_valid      (w_gnt_valid && reset),
        .i_data       (w_in),
        .o_ready      (w_buf_in_ready),
        .o_valid      (w_buf_valid),
        .o_data       (w_head_bits),
        .i_ready      (mem_req_ready),
        .o_count_next (w_count_next)
    );

    assign w_head         = w_head_bits;
    assign mem_req_valid  = w_buf_valid;
    assign mem_req_rw     = w_head.rw;
    assign mem_req_addr   = w_head.addr;
    assign mem_req_byteen = w_head.byteen;
    assign mem_req_data   = w_head.data;
    assign mem_req_tag    = w_head.tag;

    // ------------------------------------------------------------------
    // Response routing. An index outside the requester range is drained
    // (ready=1) so a corrupt tag cannot wedge the memory side; it is
    // reported through rsp_err instead.
    // ------------------------------------------------------------------
    assign w_rsp_in_range = ({1'b0, w_rsp_idx} < c_NUM_REQS_W);
    assign w_rsp_onehot   = NUM_REQS'(1) << w_rsp_idx;
    assign mem_rsp_ready  = w_rsp_in_range ? rsp_ready[w_rsp_idx] : 1'b1;
    assign rsp_valid      = (reset && mem_rsp_valid && w_rsp_in_range) ? w_rsp_onehot : '0;
    assign rsp_data       = {NUM_REQS{mem_rsp_data}};
    assign rsp_tag        = {NUM_REQS{mem_rsp_tag[c_MTAG_W-1:c_LOG_N]}};

    assign w_rsp_fire = mem_rsp_valid && mem_rsp_ready;
    assign w_rsp_ok   = w_rsp_fire && w_rsp_in_range && (r_pend[w_rsp_idx] != '0);

    assign w_inc = req_ready & ~req_rw;
    assign w_dec = w_rsp_ok ? w_rsp_onehot : '0;

    always_comb begin
        w_any_pend = 1'b0;
        for (int i = 0; i < NUM_REQS; i++) begin
            w_pend_next[i] = r_pend[i];
            if (w_inc[i] && !w_dec[i] && (r_pend[i] != c_PEND_MAX)) begin
                w_pend_next[i] = r_pend[i] + c_PEND_W'(1);
            end else if (w_dec[i] && !w_inc[i] && (r_pend[i] != '0)) begin
                w_pend_next[i] = r_pend[i] - c_PEND_W'(1);
            end
            w_any_pend = w_any_pend || (w_pend_next[i] != '0);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr_ptr <= '0;
            r_pend   <= '0;
            r_busy   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (w_req_fire) begin
                r_rr_ptr <= w_ptr_next;
            end
            r_pend <= w_pend_next;
            // Built from next-state values so busy matches the state it
            // describes in the same cycle.
            r_busy <= w_any_pend || (w_count_next != 2'd0);
            if (w_rsp_fire && !w_rsp_ok) begin
                r_err <= 1'b1;
            end
        end
    end

    assign busy    = r_busy;
    assign rsp_err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_vx_mem_bus_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_vx_mem_bus_arb
// Purpose  : Self-checking bench for vx_mem_bus_arb (N=4, MAX_PENDING=2).
//            A queue/array reference model predicts every output each cycle;
//            directed steps cover fairness, throttling, backpressure,
//            routing, errors and asynchronous reset, then random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vx_mem_bus_arb;

    localparam int N  = 4;
    localparam int AW = 30;
    localparam int DS = 4;
    localparam int TW = 8;
    localparam int MP = 2;

    logic                    clk;
    logic                    reset;
    logic [N-1:0]            req_valid;
    logic [N-1:0]            req_rw;
    logic [N-1:0][AW-1:0]    req_addr;
    logic [N-1:0][DS-1:0]    req_byteen;
    logic [N-1:0][8*DS-1:0]  req_data;
    logic [N-1:0][TW-1:0]    req_tag;
    logic [N-1:0]            req_ready;
    logic                    mem_req_valid;
    logic                    mem_req_rw;
    logic [AW-1:0]           mem_req_addr;
    logic [DS-1:0]           mem_req_byteen;
    logic [8*DS-1:0]         mem_req_data;
    logic [TW+1:0]           mem_req_tag;
    logic                    mem_req_ready;
    logic                    mem_rsp_valid;
    logic [8*DS-1:0]         mem_rsp_data;
    logic [TW+1:0]           mem_rsp_tag;
    logic                    mem_rsp_ready;
    logic [N-1:0]            rsp_valid;
    logic [N-1:0][8*DS-1:0]  rsp_data;
    logic [N-1:0][TW-1:0]    rsp_tag;
    logic [N-1:0]            rsp_ready;
    logic                    busy;
    logic                    rsp_err;

    vx_mem_bus_arb #(
        .NUM_REQS    (N),
        .ADDR_WIDTH  (AW),
        .DATA_SIZE   (DS),
        .TAG_WIDTH   (TW),
        .MAX_PENDING (MP)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_rw         (req_rw),
        .req_addr       (req_addr),
        .req_byteen     (req_byteen),
        .req_data       (req_data),
        .req_tag        (req_tag),
        .req_ready      (req_ready),
        .mem_req_valid  (mem_req_valid),
        .mem_req_rw     (mem_req_rw),
        .mem_req_addr   (mem_req_addr),
        .mem_req_byteen (mem_req_byteen),
        .mem_req_data   (mem_req_data),
        .mem_req_tag    (mem_req_tag),
        .mem_req_ready  (mem_req_ready),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .mem_rsp_tag    (mem_rsp_tag),
        .mem_rsp_ready  (mem_rsp_ready),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .rsp_tag        (rsp_tag),
        .rsp_ready      (rsp_ready),
        .busy           (busy),
        .rsp_err        (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic            rw;
        logic [AW-1:0]   addr;
        logic [DS-1:0]   be;
        logic [8*DS-1:0] data;
        logic [TW+1:0]   tag;
    } ent_t;

    // Reference model state
    ent_t q[$];
    int   pend[N];
    int   ptr;
    bit   err;

    int n_checks;
    int n_fail;

    // Observations captured in the most recent step
    logic [N-1:0]  obs_rr;
    logic          obs_mv;
    logic [AW-1:0] obs_addr;
    logic          obs_mrr;
    logic          obs_busy;
    logic [N-1:0]  obs_rv;
    logic [TW-1:0] obs_rtag3;
    logic          obs_err;
    int            obs_idx;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < N; i++) pend[i] = 0;
        ptr = 0;
        err = 1'b0;
    endtask

    task automatic rand_fields();
        for (int i = 0; i < N; i++) begin
            req_addr[i]   = AW'($urandom);
            req_byteen[i] = DS'($urandom);
            req_data[i]   = $urandom;
            req_tag[i]    = TW'($urandom);
        end
    endtask

    task automatic drive_rsp(input bit v, input int idx, input logic [TW-1:0] t);
        logic [1:0] li;
        li            = idx[1:0];
        mem_rsp_valid = v;
        mem_rsp_tag   = {t, li};
        mem_rsp_data  = $urandom;
    endtask

    // One clock cycle: check all outputs against the model with the inputs
    // currently applied, advance the model over the edge, return at negedge.
    task automatic step();
        int         g;
        int         ridx;
        bit         ready_m;
        bit         exp_busy;
        bit         rfire;
        logic [N-1:0] exp_rr;
        ent_t       e;
        logic [1:0] gi;
        #1;
        ready_m = (q.size() < 2);
        g = -1;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (ptr + k) % N;
            if (g < 0 && req_valid[j] && (req_rw[j] || pend[j] < MP)) g = j;
        end
        exp_rr = (g >= 0 && ready_m) ? N'(1 << g) : '0;
        exp_busy = (q.size() > 0);
        for (int i = 0; i < N; i++) if (pend[i] > 0) exp_busy = 1'b1;
        ridx = int'(mem_rsp_tag[1:0]);

        chk("req_ready", req_ready, exp_rr);
        chk("mem_req_valid", mem_req_valid, q.size() > 0);
        if (q.size() > 0) begin
            chk("mem_req_rw", mem_req_rw, q[0].rw);
            chk("mem_req_addr", mem_req_addr, q[0].addr);
            chk("mem_req_byteen", mem_req_byteen, q[0].be);
            chk("mem_req_data", mem_req_data, q[0].data);
            chk("mem_req_tag", mem_req_tag, q[0].tag);
        end
        chk("rsp_valid", rsp_valid, mem_rsp_valid ? N'(1 << ridx) : '0);
        chk("mem_rsp_ready", mem_rsp_ready, rsp_ready[ridx]);
        chk("rsp_tag", rsp_tag[ridx], mem_rsp_tag[TW+1:2]);
        chk("rsp_data", rsp_data[(ridx + 1) % N], mem_rsp_data);
        chk("busy", busy, exp_busy);
        chk("rsp_err", rsp_err, err);

        obs_rr    = req_ready;
        obs_mv    = mem_req_valid;
        obs_addr  = mem_req_addr;
        obs_mrr   = mem_rsp_ready;
        obs_busy  = busy;
        obs_rv    = rsp_valid;
        obs_rtag3 = rsp_tag[3];
        obs_err   = rsp_err;
        obs_idx   = -1;
        for (int i = 0; i < N; i++) if (req_ready[i]) obs_idx = i;

        // Model update: response uses the pre-edge pending count.
        rfire = mem_rsp_valid && rsp_ready[ridx];
        if (rfire) begin
            if (pend[ridx] == 0) err = 1'b1;
            else pend[ridx]--;
        end
        if (q.size() > 0 && mem_req_ready) void'(q.pop_front());
        if (exp_rr != '0) begin
            gi       = g[1:0];
            e.rw     = req_rw[g];
            e.addr   = req_addr[g];
            e.be     = req_byteen[g];
            e.data   = req_data[g];
            e.tag    = {req_tag[g], gi};
            q.push_back(e);
            if (!req_rw[g]) pend[g]++;
            ptr = (g + 1) % N;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Return every outstanding read and let the buffer empty.
    task automatic drain();
        int sel;
        req_valid     = '0;
        mem_req_ready = 1'b1;
        rsp_ready     = '1;
        for (int c = 0; c < 40; c++) begin
            sel = -1;
            for (int i = 0; i < N; i++) if (pend[i] > 0 && sel < 0) sel = i;
            if (sel >= 0) drive_rsp(1'b1, sel, TW'($urandom));
            else          drive_rsp(1'b0, 0, '0);
            step();
        end
        drive_rsp(1'b0, 0, '0);
        step();
        chk("drain_busy", obs_busy, 1'b0);
    endtask

    int accepts;
    bit have_addr;
    logic [AW-1:0] first_addr;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        model_reset();
        reset         = 1'b0;
        req_valid     = '1;
        req_rw        = '0;
        rand_fields();
        mem_req_ready = 1'b1;
        rsp_ready     = '1;
        drive_rsp(1'b1, 1, 8'h33);

        // Reset state
        #3;
        chk("rst_mem_req_valid", mem_req_valid, 1'b0);
        chk("rst_req_ready", req_ready, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_rsp_valid", rsp_valid, '0);
        drive_rsp(1'b0, 0, '0);
        @(negedge clk);
        reset = 1'b1;

        // Fairness: continuous reads from all four requesters
        req_valid = '1;
        req_rw    = '0;
        for (int k = 0; k < 8; k++) begin
            rand_fields();
            step();
            chk("fair_order", obs_idx, k % N);
            if (k == 1) chk("first_req_valid", obs_mv, 1'b1);
        end
        step();
        drain();

        // Throttle on requester 1
        req_valid = 4'b0010;
        req_rw    = '0;
        rand_fields(); step();
        rand_fields(); step();
        rand_fields(); step();
        chk("throttle_stall", obs_rr[1], 1'b0);
        req_rw = 4'b0010;
        rand_fields(); step();
        chk("throttle_write", obs_rr[1], 1'b1);
        req_rw = '0;
        drive_rsp(1'b1, 1, 8'hA1);
        rand_fields(); step();
        chk("throttle_rsp_cycle", obs_rr[1], 1'b0);
        drive_rsp(1'b0, 0, '0);
        step();
        chk("throttle_release", obs_rr[1], 1'b1);
        drain();

        // Backpressure with requester 0 writing
        mem_req_ready = 1'b0;
        req_valid     = 4'b0001;
        req_rw        = 4'b0001;
        accepts       = 0;
        have_addr     = 1'b0;
        for (int c = 0; c < 5; c++) begin
            rand_fields();
            step();
            accepts += int'(obs_rr[0]);
            if (obs_mv) begin
                if (have_addr) chk("bp_addr_stable", obs_addr, first_addr);
                else begin first_addr = obs_addr; have_addr = 1'b1; end
            end
        end
        chk("bp_accepts", accepts, 2);
        req_valid     = '0;
        mem_req_ready = 1'b1;
        step(); step(); step();
        chk("bp_drained", obs_busy, 1'b0);

        // Response routing to requester 3
        req_valid = 4'b1000;
        req_rw    = '0;
        rand_fields(); step();
        req_valid = '0;
        step(); step();
        drive_rsp(1'b1, 3, 8'h5A);
        rsp_ready = 4'b0111;
        step();
        chk("rt_mem_rsp_ready", obs_mrr, 1'b0);
        step();
        chk("rt_busy_held", obs_busy, 1'b1);
        rsp_ready = '1;
        step();
        chk("rt_rsp_valid", obs_rv, 4'b1000);
        chk("rt_rsp_tag", obs_rtag3, 8'h5A);
        drive_rsp(1'b0, 0, '0);
        step();
        chk("rt_busy_clear", obs_busy, 1'b0);

        // Read fire and response for the same requester in one cycle
        req_valid = 4'b0100;
        rand_fields(); step();
        req_valid = '0;
        step();
        req_valid = 4'b0100;
        drive_rsp(1'b1, 2, 8'h22);
        rand_fields(); step();
        chk("simul_pend", dut.r_pend[2], 1);
        drain();

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            int ri;
            req_valid     = N'($urandom);
            req_rw        = N'($urandom);
            rand_fields();
            mem_req_ready = ($urandom_range(0, 3) != 0);
            rsp_ready     = N'($urandom) | N'($urandom);
            ri            = $urandom_range(0, N - 1);
            drive_rsp((pend[ri] > 0) && ($urandom_range(0, 1) == 1), ri, TW'($urandom));
            step();
        end
        drain();

        // Response to a requester with nothing pending
        drive_rsp(1'b1, 2, 8'h11);
        step();
        drive_rsp(1'b0, 0, '0);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("err_sticky", obs_err, 1'b1);
        end

        // Asynchronous reset with buffered requests and pending reads
        mem_req_ready = 1'b0;
        req_valid     = 4'b0001;
        req_rw        = '0;
        rand_fields(); step();
        rand_fields(); step();
        req_valid = '1;
        drive_rsp(1'b1, 0, 8'h77);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_mem_req_valid", mem_req_valid, 1'b0);
        chk("mid_busy", busy, 1'b0);
        chk("mid_req_ready", req_ready, '0);
        chk("mid_rsp_valid", rsp_valid, '0);
        chk("mid_rsp_err", rsp_err, 1'b0);
        model_reset();
        drive_rsp(1'b0, 0, '0);
        @(negedge clk);
        reset         = 1'b1;
        mem_req_ready = 1'b1;
        rand_fields();
        step();
        chk("post_reset_grant", obs_rr, 4'b0001);
        // A late response to requester 1 (nothing pending after reset)
        req_valid = '0;
        drive_rsp(1'b1, 1, 8'h44);
        step();
        drive_rsp(1'b0, 0, '0);
        step();
        chk("post_reset_err", obs_err, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vx_mem_bus_arb.md
# vx_mem_bus_arb

Round-robin arbiter that shares one memory request/response channel (dcache or icache bank port) among `NUM_REQS` requesters, e.g. per-block LSU ports or fetch plus a debug requester in front of one bus. Requests pass through a registered 2-entry elastic buffer. The requester index is appended to the tag so responses can be routed back. Per-requester pending-read counters throttle each requester to `MAX_PENDING` outstanding reads, and they drive `busy` for the core's idle detection.

## Interface
- `NUM_REQS`, 4: number of requesters, ≥1
- `ADDR_WIDTH`, 30: word address width
- `DATA_SIZE`, 4: bytes per word; data width is `8*DATA_SIZE`
- `TAG_WIDTH`, 8: requester-side tag width
- `MAX_PENDING`, 16: maximum outstanding reads per requester, ≥1
- Derived, `LOG_N` = `NUM_REQS>1 ? clog2(NUM_REQS) : 0`; memory tag width is `TAG_WIDTH+LOG_N`

Ports:
- `clk` in 1: single clock
- `reset` in 1: asynchronous, active-low reset; asserted when 0
- `req_valid` in [N]: per-requester request valid
- `req_rw` in [N]: 1 = write, 0 = read
- `req_addr` in [N][ADDR_WIDTH]: request address
- `req_byteen` in [N][DATA_SIZE]: write byte enables
- `req_data` in [N][8*DATA_SIZE]: write data
- `req_tag` in [N][TAG_WIDTH]: requester tag
- `req_ready` out [N]: request accepted this cycle
- `mem_req_valid`/`_rw`/`_addr`/`_byteen`/`_data`/`_tag` out: merged request; tag is `TAG_WIDTH+LOG_N` wide
- `mem_req_ready` in 1: memory accepts
- `mem_rsp_valid` in 1, `mem_rsp_data` in 8*DATA_SIZE, `mem_rsp_tag` in TAG_WIDTH+LOG_N; `mem_rsp_ready` out 1
- `rsp_valid` out [N], `rsp_data` out [N][8*DATA_SIZE], `rsp_tag` out [N][TAG_WIDTH], `rsp_ready` in [N]
- `busy` out 1: any read pending or buffer non-empty
- `rsp_err` out 1: sticky; set when a response targets a requester with zero pending reads

## Operation
- Eligibility: `elig[i] = req_valid[i] && (req_rw[i] || pend[i] != MAX_PENDING)`. A write is never throttled.
- Grant: the first eligible requester at or after the pointer `rr_ptr`, scanning upward modulo N. Exactly one grant or none.
- `req_ready[i] = grant[i] && buf_ready`. Requesters must not make `req_valid` depend on `req_ready`.
- Pointer update: on request fire, `rr_ptr <= (grant_idx+1) mod N`. Otherwise it holds.
- Buffer entry holds `{rw, addr, byteen, data, tag = {req_tag, grant_idx}}`, with the index in the LSBs. When N==1 the tag passes unmodified.
- Buffer:
  - 2-entry FIFO; head drives `mem_req_*`; `buf_ready` is the registered "not full".
  - Push and pop in the same cycle keep the count unchanged, including a push when count==1.
  - When count==2 a push is not possible.
- Pending counters `pend[i]` are `clog2(MAX_PENDING+1)` bits wide:
  - +1 on read request fire for requester i.
  - −1 on response fire to requester i.
  - Both in the same cycle: unchanged.
  - Saturating: never below 0 or above MAX_PENDING.
- Response routing:
  - `idx = mem_rsp_tag[LOG_N-1:0]`.
  - `rsp_valid[idx] = mem_rsp_valid`; all other `rsp_valid` are 0.
  - `rsp_tag = mem_rsp_tag >> LOG_N`; `rsp_data` is broadcast to all requesters.
  - `mem_rsp_ready = rsp_ready[idx]`. This path is combinational.
- Error: `idx >= NUM_REQS` or `pend[idx]==0` at response fire sets `rsp_err`; the counter is not decremented. `rsp_err` clears only on reset.

## Timing
- Reset, asynchronous, while `reset`=0:
  - `mem_req_valid`=0, `req_ready`=0, `rr_ptr`=0, all `pend`=0, buffer empty, `busy`=0, `rsp_err`=0.
  - `rsp_valid` follows `mem_rsp_valid` combinationally and is forced 0 during reset.
- First request accepted in the first cycle after reset deasserts.
- Request latency: fire at edge t, `mem_req_valid`=1 from t+1. Zero-bubble throughput of 1 request/cycle while `mem_req_ready`=1.
- Backpressure: with `mem_req_ready`=0, two requests are absorbed, then `req_ready`=0 from the next cycle. `mem_req_*` stays stable while valid and not ready.
- Reset mid-operation: the buffer is flushed and counters are cleared. In-flight responses arriving after reset are flagged via `rsp_err`.
- `busy` is registered: `|pend || count!=0`, updated each edge.

## Structure
- Shared package `VX_gpu_pkg`: the `mem_arb_entry_t` packed struct (rw, addr, byteen, data, tag) and the `LOG_N` helper function.
- Sub-module `vx_arb_elastic_buf`: the 2-entry valid/ready buffer with registered ready, parameterized by `DATAW`.
- Round-robin grant and counters live in the top-level module. The expected size is 180–280 lines in total.

## Test plan
- Fairness: N=4, all requesters issue continuous reads, `mem_req_ready`=1.
  - Required: grant order 0,1,2,3,0,…; `mem_req_tag` LSBs follow 0,1,2,3.
  - Required: first `mem_req_valid` one cycle after the first fire.
- Throttle: MAX_PENDING=2, requester 1 sends 3 reads and no responses return.
  - Required: the third read is stalled (`req_ready[1]`=0) and writes from requester 1 still pass.
  - Required: after one response to requester 1, the third read is accepted next cycle.
- Backpressure: hold `mem_req_ready`=0 with requester 0 valid.
  - Required: exactly 2 accepts, then `req_ready`=0; `mem_req_addr` is stable.
  - Required: releasing ready drains the buffer in order.
- Response routing: `mem_rsp_tag`={0x5A,2'd3} while requester 3 has 1 pending.
  - Required: `rsp_valid`=4'b1000, `rsp_tag[3]`=0x5A, `pend[3]`→0, `busy`→0.
  - Required: with `rsp_ready[3]`=0, `mem_rsp_ready`=0 and `pend[3]` is held.
- Error and simultaneity:
  - A response to requester 2 with `pend[2]`=0 sets `rsp_err`=1 permanently.
  - A read fire and a response for the same requester in one cycle leave `pend` unchanged.
- Reset mid-operation: assert `reset`=0 asynchronously with 2 buffered requests and pending reads.
  - Required: immediately `mem_req_valid`=0, `busy`=0, `rr_ptr`=0.
